muldiv_controller: RTL and testbench
====================================

// Module: muldiv_controller
// PURPOSE
//  Iterative multiply/divide sequencer owning the HI/LO registers of the MIPS pipeline.
//  Accepts mult/multu/div/divu from the EX stage and runs a radix-2 shift-add multiply or a restoring divide, one bit per cycle.
//  Drives a stall request that the hazard logic ANDs into wpcir while mfhi/mflo or a second mul/div must wait on a busy unit.
// PARAMETERS
//  WIDTH    32  operand width; HI/LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk      in   1      system clock, rising edge
//  rst      in   1      synchronous, active-high reset
//  start    in   1      EX-stage mul/div issue strobe
//  func     in   6      funct field: 011000 mult, 011001 multu, 011010 div, 011011 divu
//  a        in   WIDTH  rs operand (multiplicand / dividend)
//  b        in   WIDTH  rt operand (multiplier / divisor)
//  rd_hi    in   1      mfhi in EX
//  rd_lo    in   1      mflo in EX
//  busy     out  1      iteration or sign-fix in progress
//  stall    out  1      combinational: busy & (start|rd_hi|rd_lo[|wr_hi|wr_lo])
//  done     out  1      one-cycle pulse, new HI/LO visible this cycle
//  dz       out  1      divide-by-zero flag, valid with done
//  hi       out  WIDTH  architectural HI
//  lo       out  WIDTH  architectural LO
// BEHAVIOUR
//  Reset: state IDLE, hi=lo=0, busy=0, done=0, dz=0, iteration counter=0; stall=0 follows busy=0.
//  States: IDLE -> RUN -> FIX -> IDLE.
//  IDLE: start=1 with a valid func latches |a|,|b| into working regs; latches sign info (signed ops only) and op type; counter=WIDTH-1; goes to RUN.
//    start=1 with any other func is ignored; state stays IDLE.
//  RUN: one iteration per edge.
//    Multiply: 2*WIDTH product accumulator.
//    Divide: restoring shift-subtract.
//    After the iteration at counter=0, go to FIX.
//  FIX (1 cycle): apply signs, then write hi/lo at the FIX->IDLE edge; done=1 and dz valid in the following cycle only.
//    mult: negate the 2W product if sign(a)^sign(b).
//    div: lo = quotient, negated if sign(a)^sign(b); hi = remainder, negated if sign(a).
//  Latency: start sampled at edge E0 -> busy=1 for cycles E0..E0+WIDTH -> hi/lo updated at edge E0+WIDTH+1 (33 cycles at WIDTH=32).
//  hi/lo hold their previous values throughout RUN/FIX; intermediate results never leak.
//  start while busy: not accepted, stall=1; the stalled EX stage re-presents start after done.
//  mfhi/mflo while busy: stall=1 until the done cycle, where busy=0, stall=0 and hi/lo are already updated.
//  Divide by zero (b==0, div or divu): hi=a (raw), lo={WIDTH{1'b1}}, no sign fix, dz=1 with done; latency unchanged.
//  div of most-negative by -1: lo=most-negative (1000..0), hi=0; no trap.
//  dz and done are zero in every cycle except the done cycle.
//  Reset mid-operation (any state): abort, return to IDLE, hi=lo=0, no done pulse.
// CONFIGURATION
//  MULDIV_MTHILO_EN defined: adds ports wr_hi in 1, wr_lo in 1, wdata in WIDTH (mthi/mtlo).
//    In IDLE, wr_hi/wr_lo write wdata into hi/lo at the next edge.
//    While busy: stall=1 and no write occurs.
//    start and a write in the same IDLE cycle: start wins, the write is dropped.
//  MULDIV_MTHILO_EN undefined: those ports are absent; hi/lo are written only by FIX or rst.
// TESTING
//  multu a=FFFFFFFF b=FFFFFFFF -> done at cycle 33, hi=FFFFFFFE lo=00000001, single-cycle done pulse.
//  mult a=FFFFFFFD(-3) b=00000005 -> hi=FFFFFFFF lo=FFFFFFF1; divu 7/2 -> hi=1 lo=3.
//  div a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; div 80000000/FFFFFFFF -> lo=80000000 hi=0.
//  divu a=00001234 b=0 -> hi=00001234 lo=FFFFFFFF, dz=1 only in the done cycle.
//  rd_lo=1 from cycle 5 of busy -> stall=1 until done; lo shows the old value until done, then the new one.
//  rst asserted at iteration 10 -> next cycle busy=0, hi=lo=0, done never pulses.
//  (MULDIV_MTHILO_EN) wr_hi=1 wdata=CAFEF00D in IDLE -> hi=CAFEF00D next cycle; the same write while busy -> stall=1, hi unchanged.

Source files
------------

// File: rtl/muldiv_controller.sv
// -----------------------------------------------------------------------------
// muldiv_controller
//   Iterative multiply/divide sequencer that owns the architectural HI/LO
//   registers. mult/multu run a radix-2 shift-add multiply and div/divu run a
//   restoring shift-subtract divide, one bit per clock. Operands are reduced to
//   magnitudes on issue and the signs are re-applied in a single FIX cycle.
//   Latency from the issue edge to the HI/LO update is WIDTH+1 edges.
//
// Optional feature: define MULDIV_MTHILO_EN to add the mthi/mtlo write port
//   (wr_hi, wr_lo, wdata). Without it HI/LO change only on FIX or rst.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   start, func  issue strobe and funct field (mult/multu/div/divu)
//   a, b         rs / rt operands
//   rd_hi, rd_lo mfhi / mflo present in EX
//   wr_hi, wr_lo, wdata   mthi / mtlo (MULDIV_MTHILO_EN only)
//   busy         iteration or sign-fix in progress
//   stall        busy and a dependent HI/LO access is being presented
//   done, dz     one-cycle completion pulse, divide-by-zero flag with done
//   hi, lo       architectural HI / LO
// -----------------------------------------------------------------------------
module muldiv_controller #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             rd_hi,
  input  logic             rd_lo,
`ifdef MULDIV_MTHILO_EN
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
  localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_e;

  // Two's-complement conditional negation; the magnitude of the most-negative
  // value wraps to itself, which is exactly the unsigned magnitude we need.
  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] x,
                                                  input logic neg);
    return neg ? (~x + ONE_W) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] x,
                                                     input logic neg);
    return neg ? (~x + ONE_2W) : x;
  endfunction

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;    // mul: {partial, multiplier}; div: {rem, quotient}
  logic [WIDTH-1:0]     opnd_q, opnd_d;  // |multiplicand| or |divisor|
  logic                 is_div_q, is_div_d;
  logic                 neg_a_q, neg_a_d;
  logic                 neg_b_q, neg_b_d;
  logic                 dzero_q, dzero_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;
  logic                 dz_q, dz_d;

  logic                 func_ok, op_signed, op_div;
  logic [WIDTH:0]       mul_add, mul_sum;
  logic [WIDTH:0]       div_shift, div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod;

  assign func_ok   = (func[5:2] == 4'b0110);
  assign op_signed = ~func[0];
  assign op_div    = func[1];

  always_comb begin
    mul_add   = acc_q[0] ? {1'b0, opnd_q} : '0;
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + mul_add;
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    prod      = cond_neg_2w(acc_q, neg_a_q ^ neg_b_q);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dzero_d  = dzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && func_ok) begin
          is_div_d = op_div;
          neg_a_d  = op_signed & a[WIDTH-1];
          neg_b_d  = op_signed & b[WIDTH-1];
          dzero_d  = op_div & (b == '0);
          if (op_div) begin
            acc_d  = {{WIDTH{1'b0}}, cond_neg_w(a, op_signed & a[WIDTH-1])};
            opnd_d = cond_neg_w(b, op_signed & b[WIDTH-1]);
          end else begin
            acc_d  = {{WIDTH{1'b0}}, cond_neg_w(b, op_signed & b[WIDTH-1])};
            opnd_d = cond_neg_w(a, op_signed & a[WIDTH-1]);
          end
          cnt_d   = CW'(WIDTH - 1);
          state_d = RUN;
        end
`ifdef MULDIV_MTHILO_EN
        // An accepted issue takes priority; the move-to is dropped.
        else begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
`endif
      end
      RUN: begin
        if (is_div_q) begin
          // Remainder always fits in WIDTH bits after the restore decision.
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      FIX: begin
        if (is_div_q) begin
          // With a zero divisor the array leaves rem=|a| and quotient=all ones,
          // so re-signing the remainder by sign(a) yields the raw dividend.
          lo_d = dzero_q ? '1 : cond_neg_w(acc_q[WIDTH-1:0], neg_a_q ^ neg_b_q);
          hi_d = cond_neg_w(acc_q[2*WIDTH-1:WIDTH], neg_a_q);
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
        done_d  = 1'b1;
        dz_d    = dzero_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    opnd_q   <= opnd_d;
    is_div_q <= is_div_d;
    neg_a_q  <= neg_a_d;
    neg_b_q  <= neg_b_d;
    dzero_q  <= dzero_d;
  end

  assign busy = (state_q != IDLE);
`ifdef MULDIV_MTHILO_EN
  assign stall = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);
`else
  assign stall = busy & (start | rd_hi | rd_lo);
`endif
  assign done = done_q;
  assign dz   = dz_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_controller.sv
// -----------------------------------------------------------------------------
// tb_muldiv_controller
//   Directed-vector bench for muldiv_controller at WIDTH=32 with hand-computed
//   HI/LO results, latency, stall and reset-abort behaviour. The mthi/mtlo
//   vectors are compiled in when MULDIV_MTHILO_EN is defined.
// -----------------------------------------------------------------------------
module tb_muldiv_controller;
  localparam int W = 32;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic         clk = 1'b0;
  logic         rst, start, rd_hi, rd_lo;
  logic [5:0]   func;
  logic [W-1:0] a, b;
  logic         busy, stall, done, dz;
  logic [W-1:0] hi, lo;
`ifdef MULDIV_MTHILO_EN
  logic         wr_hi, wr_lo;
  logic [W-1:0] wdata;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_controller #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .a(a), .b(b),
    .rd_hi(rd_hi), .rd_lo(rd_lo),
`ifdef MULDIV_MTHILO_EN
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
`endif
    .busy(busy), .stall(stall), .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, follow it to done, then check results and the pulse width.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] av, input logic [31:0] bv,
                        input logic [31:0] eh, input logic [31:0] el,
                        input logic edz);
    logic [31:0] oh, ol;
    logic        leak, bad;
    int          n;
    oh = hi; ol = lo; leak = 1'b0; bad = 1'b0;
    start = 1'b1; func = f; a = av; b = bv;
    tick();
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1 || dz !== 1'b0) bad = 1'b1;
      if (hi !== oh || lo !== ol) leak = 1'b1;
      tick();
      n++;
    end
    check({tag, " latency"}, n, 33);
    check({tag, " busy/dz while running"}, {31'b0, bad}, 0);
    check({tag, " hi/lo leak"}, {31'b0, leak}, 0);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " dz"}, {31'b0, dz}, {31'b0, edz});
    check({tag, " busy in done cycle"}, {31'b0, busy}, 0);
    tick();
    check({tag, " done width"}, {31'b0, done}, 0);
    check({tag, " dz after done"}, {31'b0, dz}, 0);
  endtask

  initial begin
    logic [31:0] oh, ol;
    logic        bad, leak, saw;
    int          n;
    rst = 1'b1; start = 1'b0; func = '0; a = '0; b = '0;
    rd_hi = 1'b0; rd_lo = 1'b1;
`ifdef MULDIV_MTHILO_EN
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
`endif
    tick(); tick();
    check("reset busy",  {31'b0, busy},  0);
    check("reset stall", {31'b0, stall}, 0);
    check("reset done",  {31'b0, done},  0);
    check("reset dz",    {31'b0, dz},    0);
    check("reset hi", hi, 32'h0);
    check("reset lo", lo, 32'h0);
    rst = 1'b0; rd_lo = 1'b0;
    tick();

    run_op("multu max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    run_op("mult -3*5", F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    run_op("divu 7/2",  F_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0);
    run_op("div -7/2",  F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("div min/-1", F_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
    run_op("divu by 0", F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1'b1);

    // Unrecognised funct with start must be ignored.
    start = 1'b1; func = 6'b100000; a = 32'h5; b = 32'h6;
    tick();
    start = 1'b0;
    check("bad func busy", {31'b0, busy}, 0);
    check("bad func hi", hi, 32'h00001234);
    tick();
    check("bad func no done", {31'b0, done}, 0);

    // mflo waiting on a busy unit, plus a second issue attempted while busy.
    oh = hi; ol = lo; bad = 1'b0; leak = 1'b0;
    start = 1'b1; func = F_MULTU; a = 32'h3; b = 32'h4;
    tick();
    start = 1'b0;
    n = 0;
    repeat (5) begin tick(); n++; end
    check("no stall without request", {31'b0, stall}, 0);
    rd_lo = 1'b1;
    #1;
    check("mflo stall", {31'b0, stall}, 1);
    start = 1'b1; func = F_DIVU; a = 32'h100; b = 32'h0;
    #1;
    check("start-while-busy stall", {31'b0, stall}, 1);
    tick(); n++;
    start = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if (stall !== 1'b1) bad = 1'b1;
      if (lo !== ol || hi !== oh) leak = 1'b1;
      tick();
      n++;
    end
    check("mflo latency", n, 33);
    check("mflo stall held", {31'b0, bad}, 0);
    check("mflo old lo held", {31'b0, leak}, 0);
    check("mflo stall released", {31'b0, stall}, 0);
    check("mflo new lo", lo, 32'h0000000C);
    check("mflo new hi", hi, 32'h0);
    check("busy-start dropped dz", {31'b0, dz}, 0);
    rd_lo = 1'b0;
    tick();
    check("busy-start not accepted", {31'b0, busy}, 0);

    // Reset in the middle of an iteration aborts without a done pulse.
    start = 1'b1; func = F_MULT; a = 32'h7; b = 32'h9;
    tick();
    start = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy", {31'b0, busy}, 0);
    check("abort hi", hi, 32'h0);
    check("abort lo", lo, 32'h0);
    saw = 1'b0;
    repeat (40) begin
      if (done === 1'b1 || busy === 1'b1) saw = 1'b1;
      tick();
    end
    check("abort no done", {31'b0, saw}, 0);

`ifdef MULDIV_MTHILO_EN
    wr_hi = 1'b1; wdata = 32'hCAFEF00D;
    tick();
    wr_hi = 1'b0;
    check("mthi idle", hi, 32'hCAFEF00D);
    check("mthi lo untouched", lo, 32'h0);
    start = 1'b1; func = F_MULTU; a = 32'h2; b = 32'h3;
    tick();
    start = 1'b0;
    wr_hi = 1'b1; wdata = 32'h12345678;
    #1;
    check("mthi busy stall", {31'b0, stall}, 1);
    tick();
    wr_hi = 1'b0;
    check("mthi busy no write", hi, 32'hCAFEF00D);
    n = 2;
    while (done !== 1'b1 && n < 40) begin tick(); n++; end
    check("mthi-run done", {31'b0, done}, 1);
    check("mthi-run hi", hi, 32'h0);
    check("mthi-run lo", lo, 32'h6);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
